// File: rtl/access_sequencer.sv
// -----------------------------------------------------------------------------
// access_sequencer
// Door-access controller wrapped around an external 4-bit code comparator.
// A keypad code is captured on a submit strobe and held on cmp_code. One cycle
// later the comparator's match result is sampled. A match opens a timed unlock
// window. A mismatch either pulses error or, after MAX_TRIES consecutive
// failures, enters a timed alarm lockout.
//
// Ports
//   clk           : system clock, all state on the rising edge
//   rst_n         : asynchronous active-low reset
//   code_in[3:0]  : keypad code, valid while submit=1
//   submit        : single-cycle check request
//   cmp_code[3:0] : registered code driven to the comparator
//   cmp_match     : comparator result (combinational from cmp_code)
//   unlock        : high for the whole OPEN state
//   error         : one-cycle pulse on a non-locking failure
//   alarm         : high for the whole LOCKOUT state
//   busy          : high in every state except IDLE
//   attempts_left : MAX_TRIES minus the consecutive-failure count
//
// Request semantics: submit is a fire-and-forget strobe. It is accepted only
// on an edge where the FSM is already in IDLE; busy=1 means any strobe is
// dropped, not queued. There is no backpressure beyond busy.
// -----------------------------------------------------------------------------
module access_sequencer #(
   parameter int MAX_TRIES   = 3,
   parameter int OPEN_CYCLES = 8,
   parameter int LOCK_CYCLES = 16,
   parameter int TMR_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] code_in,
   input  logic       submit,
   output logic [3:0] cmp_code,
   input  logic       cmp_match,
   output logic       unlock,
   output logic       error,
   output logic       alarm,
   output logic       busy,
   output logic [2:0] attempts_left
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_FAIL    = 3'd2,
      ST_OPEN    = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   localparam logic [2:0]       MAX_L  = 3'(MAX_TRIES);
   localparam logic [3:0]       MAX_W  = 4'(MAX_TRIES);
   localparam logic [TMR_W-1:0] OPEN_T = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_T = TMR_W'(LOCK_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       cmp_code_q, cmp_code_d;
   logic [2:0]       fail_cnt_q, fail_cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cmp_code_q <= 4'd0;
         fail_cnt_q <= 3'd0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         cmp_code_q <= cmp_code_d;
         fail_cnt_q <= fail_cnt_d;
         timer_q    <= timer_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cmp_code_d = cmp_code_q;
      fail_cnt_d = fail_cnt_q;
      timer_d    = timer_q;

      unique case (state_q)
         ST_IDLE: begin
            if (submit) begin
               cmp_code_d = code_in;
               state_d    = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (cmp_match) begin
               fail_cnt_d = 3'd0;
               timer_d    = OPEN_T;
               state_d    = ST_OPEN;
            end else if (({1'b0, fail_cnt_q} + 4'd1) == MAX_W) begin
               // Saturate at MAX_TRIES so attempts_left reads 0 in lockout.
               fail_cnt_d = MAX_L;
               timer_d    = LOCK_T;
               state_d    = ST_LOCKOUT;
            end else begin
               fail_cnt_d = fail_cnt_q + 3'd1;
               state_d    = ST_FAIL;
            end
         end

         ST_FAIL: begin
            state_d = ST_IDLE;
         end

         ST_OPEN: begin
            if (timer_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_LOCKOUT: begin
            if (timer_q == '0) begin
               fail_cnt_d = 3'd0;
               state_d    = ST_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs: decoded only from registered state.
   assign cmp_code      = cmp_code_q;
   assign unlock        = (state_q == ST_OPEN);
   assign error         = (state_q == ST_FAIL);
   assign alarm         = (state_q == ST_LOCKOUT);
   assign busy          = (state_q != ST_IDLE);
   assign attempts_left = MAX_L - fail_cnt_q;

endmodule

// File: tb/tb_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_access_sequencer
// Directed bench for access_sequencer with a behavioural comparator whose
// stored code is 4'b1110. Inputs are driven and outputs sampled just after
// the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_access_sequencer;

   logic       clk;
   logic       rst_n;
   logic [3:0] code_in;
   logic       submit;
   logic [3:0] cmp_code;
   logic       cmp_match;
   logic       unlock;
   logic       error;
   logic       alarm;
   logic       busy;
   logic [2:0] attempts_left;

   int tests_run = 0;
   int tests_failed = 0;

   access_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .code_in       (code_in),
      .submit        (submit),
      .cmp_code      (cmp_code),
      .cmp_match     (cmp_match),
      .unlock        (unlock),
      .error         (error),
      .alarm         (alarm),
      .busy          (busy),
      .attempts_left (attempts_left)
   );

   // Comparator with fixed code 4'b1110.
   assign cmp_match = (cmp_code == 4'b1110);

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Present code for one rising edge; returns in the CHECK cycle.
   task automatic do_submit(input logic [3:0] code);
      step();
      code_in = code;
      submit  = 1'b1;
      step();
      submit  = 1'b0;
   endtask

   // Outputs as a packed vector {unlock, error, alarm, busy}.
   function automatic logic [7:0] flags();
      return {4'b0, unlock, error, alarm, busy};
   endfunction

   // Submit a wrong code and expect a non-locking error pulse.
   task automatic expect_fail(input logic [3:0] code, input logic [2:0] att, input string tag);
      do_submit(code);
      check({tag, "_check_busy"}, flags(), 8'b0001);
      step();
      check({tag, "_error"}, flags(), 8'b0101);
      check({tag, "_att"}, 8'(attempts_left), 8'(att));
      step();
      check({tag, "_idle"}, flags(), 8'b0000);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n   = 1'b0;
      code_in = 4'd0;
      submit  = 1'b0;
      #12;
      rst_n   = 1'b1;

      // Reset state, idle 5 cycles.
      repeat (5) step();
      check("rst_flags", flags(), 8'b0000);
      check("rst_att", 8'(attempts_left), 8'd3);
      check("rst_cmp_code", 8'(cmp_code), 8'h0);

      // Correct code: 8-cycle unlock window.
      do_submit(4'b1110);
      check("ok_cmp_code", 8'(cmp_code), 8'he);
      check("ok_check_flags", flags(), 8'b0001);
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("ok_open_%0d", i), flags(), 8'b1001);
      end
      step();
      check("ok_after_open", flags(), 8'b0000);

      // Single failure then success restores attempts.
      expect_fail(4'b0110, 3'd2, "f1");
      do_submit(4'b1110);
      step();
      check("recover_unlock", flags(), 8'b1001);
      check("recover_att", 8'(attempts_left), 8'd3);
      repeat (8) step();
      check("recover_idle", flags(), 8'b0000);

      // Three consecutive failures: lockout with submit pulsed every cycle.
      expect_fail(4'b0000, 3'd2, "l1");
      expect_fail(4'b1111, 3'd1, "l2");
      do_submit(4'b0111);
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("lock_alarm_%0d", i), flags(), 8'b0011);
         check($sformatf("lock_att_%0d", i), 8'(attempts_left), 8'd0);
         check($sformatf("lock_code_%0d", i), 8'(cmp_code), 8'h7);
         code_in = 4'b1110;
         submit  = 1'b1;
      end
      step();
      submit = 1'b0;
      check("lock_end_flags", flags(), 8'b0000);
      check("lock_end_att", 8'(attempts_left), 8'd3);
      step();
      check("lock_no_requeue", flags(), 8'b0000);

      // Submit pulsed throughout OPEN: window length unchanged, no re-open.
      do_submit(4'b1110);
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("busy_open_%0d", i), flags(), 8'b1001);
         code_in = 4'b1110;
         submit  = 1'b1;
      end
      step();
      submit = 1'b0;
      check("busy_open_end", flags(), 8'b0000);
      step();
      check("busy_open_no_reopen", flags(), 8'b0000);

      // Sweep low bits with upper bits 2'b11.
      expect_fail(4'b1100, 3'd2, "sw00");
      expect_fail(4'b1101, 3'd1, "sw01");
      do_submit(4'b1110);
      step();
      check("sw10_unlock", flags(), 8'b1001);
      check("sw10_att", 8'(attempts_left), 8'd3);
      repeat (8) step();
      check("sw10_idle", flags(), 8'b0000);
      expect_fail(4'b1111, 3'd2, "sw11");

      // Asynchronous reset in the middle of OPEN.
      do_submit(4'b1110);
      step();
      step();
      check("mid_open_unlock", flags(), 8'b1001);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_flags", flags(), 8'b0000);
      check("async_rst_att", 8'(attempts_left), 8'd3);
      check("async_rst_code", 8'(cmp_code), 8'h0);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_idle", flags(), 8'b0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/access_sequencer.md
Name: access_sequencer

Overview:
- Controller that sequences the 4-bit code comparator for the door-access path.
- Captures a keypad code on a submit strobe and drives it onto the comparator input.
- Samples the comparator's match result and drives a timed unlock window.
- Counts consecutive failed attempts and enforces a timed alarm lockout after MAX_TRIES failures.

Parameters:
- MAX_TRIES, 3, consecutive failures that trigger lockout (range 1..7).
- OPEN_CYCLES, 8, clock cycles unlock is held high (minimum 1).
- LOCK_CYCLES, 16, clock cycles alarm/lockout lasts (minimum 1).
- TMR_W, 8, timer width; must hold max(OPEN_CYCLES, LOCK_CYCLES)-1.

Ports:
- clk  input  1  system clock; one clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- code_in  input  4  keypad code, valid when submit=1.
- submit  input  1  single-cycle strobe requesting a check.
- cmp_code  output  4  registered code driven to the comparator's entered input.
- cmp_match  input  1  comparator match output (combinational from cmp_code).
- unlock  output  1  door release, high for the whole OPEN state.
- error  output  1  one-cycle pulse on a non-locking failure.
- alarm  output  1  high for the whole LOCKOUT state.
- busy  output  1  high in any state other than IDLE.
- attempts_left  output  3  MAX_TRIES minus fail_cnt.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE; cmp_code=0, fail_cnt=0, timer=0.
  - unlock=0, error=0, alarm=0, busy=0; attempts_left=MAX_TRIES.
- All outputs are Moore outputs, decoded from state and registers. No combinational path from any input to any output.
- IDLE:
  - submit=1: cmp_code<=code_in; go to CHECK.
  - submit=0: stay in IDLE.
- CHECK (exactly 1 cycle): sample cmp_match.
  - match=1: fail_cnt<=0; timer<=OPEN_CYCLES-1; go to OPEN.
  - match=0 and fail_cnt+1==MAX_TRIES: fail_cnt<=MAX_TRIES; timer<=LOCK_CYCLES-1; go to LOCKOUT.
  - match=0 otherwise: fail_cnt<=fail_cnt+1; go to FAIL.
- FAIL (exactly 1 cycle): error=1; go to IDLE next cycle.
- OPEN:
  - unlock=1.
  - timer==0: go to IDLE; otherwise timer decrements.
  - unlock is high for exactly OPEN_CYCLES cycles.
- LOCKOUT:
  - alarm=1.
  - timer==0: fail_cnt<=0, go to IDLE; otherwise timer decrements.
  - alarm is high for exactly LOCK_CYCLES cycles.
- Latency: submit sampled at edge N → CHECK from N, result state (OPEN/FAIL/LOCKOUT) from edge N+1.
- submit while busy=1 is ignored and dropped, not queued. cmp_code holds its value outside IDLE.
- submit on the same edge IDLE is re-entered is not accepted. The first accepted submit is sampled while in IDLE.
- A success clears fail_cnt, so failures must be consecutive to cause lockout.
- MAX_TRIES=1: the first failure goes directly to LOCKOUT, and error never pulses.
- fail_cnt saturates at MAX_TRIES and never wraps.
- Timer only decrements in OPEN and LOCKOUT, and never underflows.
- unlock, alarm and error are mutually exclusive in every cycle.

Test Plan (comparator fixed code 4'b1110, default parameters):
- Reset then idle 5 cycles → all outputs 0, attempts_left=3, cmp_code=0. Assert rst_n=0 mid-OPEN → unlock drops immediately and state is IDLE.
- submit with code_in=4'b1110 → cmp_code=4'b1110 next cycle; unlock=1 for exactly 8 cycles starting 2 edges after submit; then busy=0.
- submit 4'b0110 → error single-cycle pulse; attempts_left 3→2. Then submit 4'b1110 → unlock; attempts_left returns to 3.
- Three consecutive wrong codes (4'b0000, 4'b1111, 4'b0111) → error pulses after the first two; alarm=1 for exactly 16 cycles after the third; attempts_left 0 during lockout, 3 afterward.
- During OPEN and LOCKOUT, pulse submit with 4'b1110 every cycle → no effect on cmp_code, timers, or state; no extra unlock window.
- Lower two bits of code_in swept with upper bits 2'b11: only 4'b1110 unlocks; 4'b1100, 4'b1101 and 4'b1111 each yield FAIL.
